hazard_sched: RTL and testbench

Scoreboard-based hazard scheduler for the pipelined core's decode stage. It tracks the destination registers of instructions in flight in EX, MEM and WB. When a decoded instruction's sources collide with a pending write, it holds fetch/decode and injects bubbles into EX. It also sequences halt draining and keeps a saturating stall-cycle counter for performance debug.

---
 rtl/hazard_sched.sv | 116 +++++++++++
 tb/tb_hazard_sched.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_sched.sv
// Decode-stage hazard scheduler: tracks in-flight destinations, stalls dependent
// instructions, drains the pipe on HALT and counts stall cycles. Option: HAZARD_FWD_EN.
module hazard_sched #(
  parameter int unsigned NSLOT = 3,
  parameter int unsigned CNTW  = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [2:0]      id_rs,
  input  logic            id_rs_used,
  input  logic [2:0]      id_rt,
  input  logic            id_rt_used,
  input  logic [2:0]      id_rd,
  input  logic            id_wr,
  input  logic            id_load,
  input  logic            id_halt,
  input  logic            flush,
  output logic            stall,
  output logic            bubble,
  output logic            halted,
  output logic [7:0]      busy,
  output logic [CNTW-1:0] stall_cnt
);

  localparam int unsigned RW = 3;

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  state_t           r_state;
  logic [NSLOT-1:0] r_v;
  logic [NSLOT-1:0] r_ld;
  logic [RW-1:0]    r_rd [NSLOT];
  logic [CNTW-1:0]  r_cnt;
  logic             r_halted;

  logic w_hazard;
  logic w_issue;
  logic w_post_empty;

  // Source collision against pending writes
  always_comb begin
    w_hazard = 1'b0;
`ifdef HAZARD_FWD_EN
    if (r_v[0] && r_ld[0]) begin
      if (id_rs_used && (r_rd[0] == id_rs)) w_hazard = 1'b1;
      if (id_rt_used && (r_rd[0] == id_rt)) w_hazard = 1'b1;
    end
`else
    for (int i = 0; i < int'(NSLOT); i++) begin
      if (r_v[i]) begin
        if (id_rs_used && (r_rd[i] == id_rs)) w_hazard = 1'b1;
        if (id_rt_used && (r_rd[i] == id_rt)) w_hazard = 1'b1;
      end
    end
`endif
  end

`ifndef HAZARD_FWD_EN
  // Load flags only matter for load-use detection with forwarding
  logic w_unused_ld;
  assign w_unused_ld = ^r_ld;
`endif

  assign w_issue      = id_valid & ~flush & ~w_hazard & (r_state == RUN);
  assign w_post_empty = ~(w_issue & id_wr) & ~(|r_v[NSLOT-2:0]);

  assign stall  = (id_valid & w_hazard & ~flush) | (r_state != RUN);
  assign bubble = ~w_issue;

  always_comb begin
    busy = '0;
    for (int i = 0; i < int'(NSLOT); i++) begin
      if (r_v[i]) busy[r_rd[i]] = 1'b1;
    end
  end

  assign halted    = r_halted;
  assign stall_cnt = r_cnt;

  // Slot shift, halt FSM and saturating stall counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= RUN;
      r_v      <= '0;
      r_ld     <= '0;
      r_cnt    <= '0;
      r_halted <= 1'b0;
      for (int i = 0; i < int'(NSLOT); i++) r_rd[i] <= '0;
    end else begin
      r_v  <= {r_v[NSLOT-2:0], w_issue & id_wr};
      r_ld <= {r_ld[NSLOT-2:0], id_load};
      for (int i = 1; i < int'(NSLOT); i++) r_rd[i] <= r_rd[i-1];
      r_rd[0] <= id_rd;

      if (stall && (r_cnt != {CNTW{1'b1}})) r_cnt <= r_cnt + CNTW'(1);

      case (r_state)
        RUN: begin
          if (w_issue && id_halt) r_state <= DRAIN;
        end
        DRAIN: begin
          if (w_post_empty) begin
            r_state  <= HALTED;
            r_halted <= 1'b1;
          end
        end
        HALTED: begin
          r_halted <= 1'b1;
        end
        default: r_state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_sched.sv
// Scoreboarded random + directed bench for hazard_sched against a slot-list model.
module tb_hazard_sched;
  localparam int unsigned NSLOT = 3;
  localparam int unsigned CNTW  = 16;
`ifdef HAZARD_FWD_EN
  localparam int EXP_DEP = 0;
  localparam int EXP_LU  = 1;
`else
  localparam int EXP_DEP = 3;
  localparam int EXP_LU  = 3;
`endif

  logic clk = 1'b0;
  logic rst;
  logic id_valid, id_rs_used, id_rt_used, id_wr, id_load, id_halt, flush;
  logic [2:0] id_rs, id_rt, id_rd;
  logic stall, bubble, halted;
  logic [7:0] busy;
  logic [CNTW-1:0] stall_cnt;

  hazard_sched #(.NSLOT(NSLOT), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
    .id_rt(id_rt), .id_rt_used(id_rt_used), .id_rd(id_rd), .id_wr(id_wr),
    .id_load(id_load), .id_halt(id_halt), .flush(flush), .stall(stall),
    .bubble(bubble), .halted(halted), .busy(busy), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        bubble;
    logic        halted;
    logic [7:0]  busy;
    logic [15:0] cnt;
  } exp_t;

  typedef struct {
    logic       v;
    logic [2:0] rd;
    logic       ld;
  } ent_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  // Reference model: in-flight writers as a list indexed by age (0 = EX)
  ent_t inflight[NSLOT];
  int   mstate;   // 0 running, 1 draining, 2 halted
  int   mcnt;
  logic last_iss;

  task automatic chk(input string nm, input int act, input int ex);
    total++;
    if (act != ex) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, ex, $time);
    end
  endtask

  function automatic logic reads(input logic [2:0] r);
    return (id_rs_used && id_rs == r) || (id_rt_used && id_rt == r);
  endfunction

  function automatic logic m_hazard();
    logic h = 1'b0;
`ifdef HAZARD_FWD_EN
    h = inflight[0].v && inflight[0].ld && reads(inflight[0].rd);
`else
    foreach (inflight[i]) if (inflight[i].v && reads(inflight[i].rd)) h = 1'b1;
`endif
    return h;
  endfunction

  task automatic m_reset();
    foreach (inflight[i]) inflight[i] = '{1'b0, 3'd0, 1'b0};
    mstate = 0;
    mcnt   = 0;
  endtask

  // One cycle: predict outputs for current inputs, queue them, advance model across the edge
  task automatic step();
    exp_t e;
    logic h, iss, any;
    if (!rst) m_reset();
    h   = m_hazard();
    iss = id_valid && !flush && !h && mstate == 0;
    e.stall  = (id_valid && h && !flush) || mstate != 0;
    e.bubble = !iss;
    e.halted = (mstate == 2);
    e.busy   = 8'h00;
    foreach (inflight[i]) if (inflight[i].v) e.busy = e.busy | (8'h01 << inflight[i].rd);
    e.cnt = 16'(mcnt);
    q.push_back(e);
    last_iss = iss;
    if (rst) begin
      for (int i = NSLOT - 1; i > 0; i--) inflight[i] = inflight[i-1];
      inflight[0] = '{iss && id_wr, id_rd, id_load};
      any = 1'b0;
      foreach (inflight[i]) any = any | inflight[i].v;
      if (mstate == 0 && iss && id_halt) mstate = 1;
      else if (mstate == 1 && !any) mstate = 2;
      if (e.stall && mcnt < 65535) mcnt++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_ins(input logic v, input logic ru, input logic [2:0] rs,
                         input logic tu, input logic [2:0] rt, input logic [2:0] rd,
                         input logic wr, input logic ld, input logic hlt);
    id_valid = v; id_rs_used = ru; id_rs = rs; id_rt_used = tu; id_rt = rt;
    id_rd = rd; id_wr = wr; id_load = ld; id_halt = hlt; flush = 1'b0;
  endtask

  task automatic idle();
    set_ins(1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b0;
    step();
    rst = 1'b1;
  endtask

  // Hold the current instruction until it issues, bounded
  task automatic hold_until_issue(input string nm);
    logic done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      step();
      done = last_iss;
    end
    chk(nm, int'(done), 1);
  endtask

  // Monitor: compare every presented cycle against the scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("stall",     int'(stall),     int'(e.stall));
        chk("bubble",    int'(bubble),    int'(e.bubble));
        chk("halted",    int'(halted),    int'(e.halted));
        chk("busy",      int'(busy),      int'(e.busy));
        chk("stall_cnt", int'(stall_cnt), int'(e.cnt));
      end
    end
  end

  initial begin
    rst = 1'b0;
    idle();
    m_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Random stream with periodic mid-stream resets
    for (int n = 0; n < 800; n++) begin
      id_valid   = ($urandom % 4) != 0;
      id_rs      = 3'($urandom % 8);
      id_rt      = 3'($urandom % 8);
      id_rd      = 3'($urandom % 8);
      id_rs_used = 1'($urandom % 2);
      id_rt_used = 1'($urandom % 2);
      id_wr      = ($urandom % 4) != 0;
      id_load    = id_wr && (($urandom % 3) == 0);
      id_halt    = ($urandom % 50) == 0;
      flush      = ($urandom % 8) == 0;
      rst        = (n % 97) != 96;
      step();
      rst = 1'b1;
    end

    // Reset asserted asynchronously with slots full
    set_ins(1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 3'd1, 1'b1, 1'b0, 1'b0);
    step();
    id_rd = 3'd2; step();
    id_rd = 3'd3; step();
    #2 rst = 1'b0;
    #1;
    chk("async_rst_busy", int'(busy), 0);
    chk("async_rst_cnt",  int'(stall_cnt), 0);
    chk("async_rst_halted", int'(halted), 0);
    @(posedge clk);
    #1;
    do_reset();

    // ALU producer then dependent consumer
    do_reset();
    set_ins(1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 3'd3, 1'b1, 1'b0, 1'b0); step();
    set_ins(1'b1, 1'b1, 3'd3, 1'b1, 3'd1, 3'd4, 1'b1, 1'b0, 1'b0);
    hold_until_issue("dep_issue");
    chk("dep_stalls", int'(stall_cnt), EXP_DEP);
    idle(); step(); step(); step();

    // Load then load-use consumer
    do_reset();
    set_ins(1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 3'd2, 1'b1, 1'b1, 1'b0); step();
    set_ins(1'b1, 1'b1, 3'd2, 1'b1, 3'd2, 3'd5, 1'b1, 1'b0, 1'b0);
    hold_until_issue("lu_issue");
    chk("lu_stalls", int'(stall_cnt), EXP_LU);
    idle(); step(); step(); step();

    // Stalled load-use consumer squashed by flush
    do_reset();
    set_ins(1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 3'd2, 1'b1, 1'b1, 1'b0); step();
    set_ins(1'b1, 1'b1, 3'd2, 1'b0, 3'd0, 3'd6, 1'b1, 1'b0, 1'b0);
    flush = 1'b1;
    step();
    chk("flush_cnt", int'(stall_cnt), 0);
    idle(); step(); step(); step();

    // Halt with a store and an ALU write ahead of it, then id_valid toggling
    do_reset();
    set_ins(1'b1, 1'b1, 3'd1, 1'b1, 3'd2, 3'd0, 1'b0, 1'b0, 1'b0); step();
    set_ins(1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 3'd7, 1'b1, 1'b0, 1'b0); step();
    set_ins(1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1); step();
    for (int k = 0; k < 8; k++) begin
      set_ins(1'(k % 2), 1'b0, 3'd0, 1'b0, 3'd0, 3'd1, 1'b1, 1'b0, 1'(k % 3 == 0));
      step();
    end
    chk("halt_sticky", int'(halted), 1);

    // Saturate the stall counter while halted
    idle();
    for (int k = 0; k < 65541; k++) step();
    chk("cnt_sat", int'(stall_cnt), 16'hFFFF);

    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
